// File: rtl/td4_pkg.sv
// Shared TD4 definitions: loader state encoding, memory geometry and the
// nibble layout of a program word {immediate, opcode}.
package td4_pkg;

  localparam int unsigned TD4_ADDR_W   = 4;
  localparam int unsigned TD4_WORD_W   = 8;
  localparam int unsigned TD4_NIBBLE_W = 4;
  localparam int unsigned TD4_OPC_LSB  = 0;
  localparam int unsigned TD4_IMM_LSB  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// TD4 program-memory write port: the loader drives it (master), the memory
// side observes it (slave).
interface prog_loader_if
  import td4_pkg::*;
#(
  parameter int ADDR_W = TD4_ADDR_W
);
  logic [ADDR_W-1:0]       mem_address;
  logic [TD4_NIBBLE_W-1:0] mem_opcode;
  logic [TD4_NIBBLE_W-1:0] mem_immediate;
  logic                    mem_write;

  modport master (output mem_address, mem_opcode, mem_immediate, mem_write);
  modport slave  (input  mem_address, mem_opcode, mem_immediate, mem_write);
endinterface

// File: rtl/prog_loader_sync_edge.sv
// N-stage synchronizer for an asynchronous pin, with one-clk rising and
// falling edge pulses derived from the last two synchronized samples.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/prog_loader.sv
// Serial TD4 program loader: shifts bytes MSB first on ser_clk and writes
// them to sequential addresses while holding the CPU halted.
// Optional trailer checksum: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import td4_pkg::*;
#(
  parameter int WORDS       = 16,
  parameter int ADDR_W      = TD4_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_en,
  input  logic           ser_clk,
  input  logic           ser_data,
  prog_loader_if.master  mem,
  output logic           cpu_halt,
  output logic           busy,
  output logic           done,
  output logic           err
);
  loader_state_t state, state_nxt;

  logic load_q, load_rise, load_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic data_q, data_rise, data_fall;
  logic unused_sync;

  logic [ADDR_W-1:0]     addr;
  logic [2:0]            bitcnt;
  logic [TD4_WORD_W-1:0] shift_q, shift_nxt;
  logic [ADDR_W-1:0]     out_addr;
  logic [TD4_WORD_W-1:0] out_word;
  logic                  last_word;
  logic                  byte_end;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk(clk), .rst_n(rst_n), .d(load_en), .q(load_q), .rise(load_rise), .fall(load_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(ser_clk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(ser_data), .q(data_q), .rise(data_rise), .fall(data_fall)
  );
  assign unused_sync = ^{load_fall, sclk_q, sclk_fall, data_rise, data_fall};

  assign shift_nxt = {shift_q[TD4_WORD_W-2:0], data_q};
  assign last_word = (addr == ADDR_W'(WORDS - 1));
  assign byte_end  = sclk_rise && (bitcnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort is tested before the serial edge so a dropping load_en always wins.
  always_comb begin
    state_nxt = state;
    cpu_halt  = (state != IDLE);
    busy      = (state == SHIFT) || (state == WRITE);
    done      = (state == DONE);
    unique case (state)
      IDLE:  if (load_rise) state_nxt = SHIFT;
      SHIFT: begin
        if (!load_q)       state_nxt = IDLE;
        else if (byte_end) state_nxt = WRITE;
      end
      WRITE: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        state_nxt = last_word ? CHECK : SHIFT;
`else
        state_nxt = last_word ? DONE : SHIFT;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK: begin
        if (!load_q)       state_nxt = IDLE;
        else if (byte_end) state_nxt = DONE;
      end
`endif
      DONE:    if (!load_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The output word is captured on entry to WRITE so it holds afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      bitcnt   <= '0;
      shift_q  <= '0;
      out_addr <= '0;
      out_word <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_rise) begin
            addr    <= '0;
            bitcnt  <= '0;
            shift_q <= '0;
          end
        end
        SHIFT, CHECK: begin
          if (load_q && sclk_rise) begin
            shift_q <= shift_nxt;
            bitcnt  <= bitcnt + 3'd1;
          end
        end
        WRITE: begin
          bitcnt <= sclk_rise ? 3'd1 : 3'd0;
          if (sclk_rise)  shift_q <= shift_nxt;
          if (!last_word) addr    <= addr + 1'b1;
        end
        default: ;
      endcase
      if (state == SHIFT && state_nxt == WRITE) begin
        out_addr <= addr;
        out_word <= shift_nxt;
      end
    end
  end

  assign mem.mem_write     = (state == WRITE);
  assign mem.mem_address   = out_addr;
  assign mem.mem_opcode    = out_word[TD4_OPC_LSB +: TD4_NIBBLE_W];
  assign mem.mem_immediate = out_word[TD4_IMM_LSB +: TD4_NIBBLE_W];

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [TD4_WORD_W-1:0] sum;
  logic [TD4_WORD_W-1:0] check_total;
  logic                  err_q;

  assign check_total = sum + shift_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (state == IDLE && load_rise) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (state == WRITE) begin
      sum <= sum + out_word;
    end else if (state == CHECK && load_q && byte_end && check_total != '0) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
Serial program loader that fills the 16x8 TD4 program memory through the memory's write port. It shifts bytes in from chip pins on a slow external serial clock and issues one write strobe per byte at sequential addresses. It holds the CPU halted while loading. It sits between the Tiny Tapeout input pins and the memory write port, muxed with the CPU address by the top level.

Parameters:
WORDS, 16, number of words loaded per session (must equal 2**ADDR_W)
ADDR_W, 4, memory address width
SYNC_STAGES, 2, flip-flop stages on each asynchronous pin input (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
load_en  in  1  async pin; high = loading session requested
ser_clk  in  1  async pin; serial bit clock, data sampled on its rising edge
ser_data  in  1  async pin; serial data, MSB first
mem_address  out  ADDR_W  write address to memory
mem_opcode  out  4  low nibble of the assembled byte
mem_immediate  out  4  high nibble of the assembled byte
mem_write  out  1  one-clk write strobe
cpu_halt  out  1  high while a session is active or done-but-not-released
busy  out  1  high in SHIFT or WRITE
done  out  1  high in DONE state
err  out  1  checksum mismatch flag (see Optional Feature)

Behaviour:
- Reset values: all outputs 0. Internal address, bit counter and shift register are 0. State is IDLE.
- load_en, ser_clk and ser_data each pass through a SYNC_STAGES synchronizer. A ser_clk rising edge is detected from the last two synchronized samples.
- ser_data is sampled from its synchronized copy in the same cycle the edge is detected. Pin-to-sample latency is SYNC_STAGES+1 clk.
- Source constraint: ser_clk high and low time each >= SYNC_STAGES+2 clk. ser_data is stable from 1 clk before to SYNC_STAGES+2 clk after the ser_clk rise.
- Byte format, MSB first: bits[7:4] = immediate, bits[3:0] = opcode. This matches the memory word {immediate, opcode}.
- IDLE:
  - cpu_halt=0.
  - A synchronized load_en rising edge moves to SHIFT and clears addr, bitcnt and shift register.
  - cpu_halt=1 from that same transition onward.
- SHIFT:
  - Each detected edge does shift <= {shift[6:0], data} and bitcnt++.
  - At the 8th bit, go to WRITE on the next clk.
- WRITE (exactly 1 clk):
  - mem_write=1, mem_address=addr, {mem_immediate, mem_opcode}=shift.
  - bitcnt clears.
  - If addr==WORDS-1, go to DONE. Otherwise addr++ and return to SHIFT.
- DONE:
  - done=1, cpu_halt=1.
  - A synchronized load_en low moves to IDLE, which releases cpu_halt the next clk.
- Outside WRITE: mem_address holds its last value, data outputs hold, mem_write=0.
- Abort: load_en low while in SHIFT moves to IDLE next clk.
  - Words already written stay written; the partial byte is discarded.
  - err is unchanged.
- ser_clk edges in IDLE or DONE are ignored.
- A ser_clk edge during WRITE cannot occur under the timing constraint. If one does, it is still shifted into the next byte.
- Simultaneous events: abort (load_en low) has priority over a ser_clk edge in the same cycle.
- A new load_en rising edge from IDLE clears err and starts a fresh session at address 0.
- Reset mid-session: immediate return to reset values. Memory contents are governed by the memory's own reset.
- Address wrap: addr never wraps. DONE is entered after the WORDS-th write.

Optional Feature:
Macro PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit modulo-256 sum of all WORDS bytes accumulates.
  - After the last WRITE the FSM enters state CHECK instead of DONE and shifts one more byte without writing.
  - On its 8th bit: sum+byte != 8'h00 sets err=1. Either way the FSM goes to DONE.
  - err is sticky until the next session start or reset.
- Disabled: no CHECK state, no accumulator, err tied 0.

Decomposition:
- Shared package td4_pkg: loader state enum (IDLE, SHIFT, WRITE, CHECK, DONE), TD4_ADDR_W=4, TD4_WORD_W=8, nibble field positions.
- One sub-module, sync_edge: an N-stage synchronizer with rising/falling edge pulses. It is instantiated three times: edges are used for ser_clk and load_en, the level only for ser_data.

Test Plan:
- Reset then idle: all outputs 0; ser_clk toggling with load_en=0 -> no mem_write.
- Load 16 bytes 0x00..0x0F:
  - exactly 16 mem_write pulses, each 1 clk wide.
  - address k gets opcode=k, immediate=0.
  - done=1 and cpu_halt=1 afterwards; load_en low -> cpu_halt=0 in <=SYNC_STAGES+2 clk.
- Byte 0xB3 at address 0 -> mem_immediate=4'hB, mem_opcode=4'h3 during the strobe (MSB-first check).
- Abort after 5 words plus 3 bits:
  - 5 writes only; state IDLE; busy=0.
  - A new session's first write lands at address 0.
- rst_n asserted mid-byte at word 7 -> outputs 0 immediately; the next session restarts at address 0.
- PROG_LOADER_CHECKSUM_EN:
  - 16 bytes 0x01 then 0xF0 -> err=0, done=1.
  - The same with trailer 0xF1 -> err=1, 16 writes only.
